// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: phase encodings, lamp patterns and phase durations
package traffic_light_pkg;

    typedef enum logic [2:0] {
        PH_VG, PH_VY1, PH_YY1, PH_HY1, PH_HG, PH_HY2, PH_YY2, PH_VY2
    } phase_e;

    // lamp order {hr,hy,hg,vr,vy,vg}
    localparam logic [5:0] L_VG  = 6'b100001;
    localparam logic [5:0] L_VY  = 6'b100010;
    localparam logic [5:0] L_YY  = 6'b010010;
    localparam logic [5:0] L_HY  = 6'b010100;
    localparam logic [5:0] L_HG  = 6'b001100;
    localparam logic [5:0] L_OFF = 6'b000000;
    localparam logic [5:0] L_ALL = 6'b111111;

    function automatic int dur(phase_e ph, int t_vg, int t_hg, int t_y, int t_yy);
        return ph == PH_VG ? t_vg :
               ph == PH_HG ? t_hg :
               (ph == PH_YY1 || ph == PH_YY2) ? t_yy : t_y;
    endfunction

    function automatic logic [5:0] lamps(phase_e ph);
        return ph == PH_VG ? L_VG :
               ph == PH_HG ? L_HG :
               (ph == PH_YY1 || ph == PH_YY2) ? L_YY :
               (ph == PH_HY1 || ph == PH_HY2) ? L_HY : L_VY;
    endfunction

endpackage

// File: rtl/traffic_light_if.sv
// traffic_light_if: mode/demand inputs and lamp/countdown outputs of the crossing
interface traffic_light_if #(parameter int CNT_W = 8);
    logic             blank, test, flicker, hreq, vreq;
    logic             hr, hy, hg, vr, vy, vg;
    logic [CNT_W-1:0] count;
    logic [2:0]       phase;

    modport master (
        output blank, test, flicker, hreq, vreq,
        input  hr, hy, hg, vr, vy, vg, count, phase
    );

    modport slave (
        input  blank, test, flicker, hreq, vreq,
        output hr, hy, hg, vr, vy, vg, count, phase
    );
endinterface

// File: rtl/traffic_light_tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle countdown tick every TICK_DIV cycles
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = cnt_q == W'(TICK_DIV - 1);

    // wrap after the tick cycle; restart realigns the tick to the override exit
    always_comb cnt_d = (restart || tick) ? '0 : cnt_q + W'(1);

    // prescaler register
    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: 8-phase two-road signal controller with demand truncation and override modes
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter int CNT_W      = 8,
    parameter int T_VG       = 15,
    parameter int T_HG       = 10,
    parameter int T_Y        = 5,
    parameter int T_YY       = 1,
    parameter int T_MIN_G    = 5,
    parameter int FLASH_HALF = 1
) (
    input  logic clk,
    input  logic clr,
    traffic_light_if.slave tl
);
    localparam int FW = FLASH_HALF > 1 ? $clog2(FLASH_HALF) : 1;

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [5:0]       lamp_q, lamp_d;
    logic             flash_q, flash_d, fl_q, fresh;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             tick, ovr, flk, exit_ovr, adv;

    assign ovr = tl.blank | ~tl.test | tl.flicker;
    assign flk = tl.flicker & ~tl.blank & tl.test;
    // overrides park count at 0, which normal mode never shows
    assign exit_ovr = ~ovr & (count_q == '0);
    assign adv = tick & ((count_q == CNT_W'(1)) ||
                 (phase_q == PH_VG && tl.hreq && count_q <= CNT_W'(T_VG - T_MIN_G + 1)) ||
                 (phase_q == PH_HG && tl.vreq && count_q <= CNT_W'(T_HG - T_MIN_G + 1)));

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk     (clk),
        .clr     (clr),
        .restart (exit_ovr),
        .tick    (tick)
    );

    // flash bit restarts lit on every flicker entry, then toggles each FLASH_HALF ticks
    always_comb begin
        fresh   = ~flk | ~fl_q;
        flash_d = fresh ? 1'b1 : (tick && fcnt_q == FW'(FLASH_HALF - 1)) ? ~flash_q : flash_q;
        fcnt_d  = fresh ? '0 : !tick ? fcnt_q : (fcnt_q == FW'(FLASH_HALF - 1)) ? '0 : fcnt_q + FW'(1);
    end

    // phase/countdown next state and the lamp pattern that goes with it
    always_comb begin
        phase_d = phase_q;
        count_d = count_q;
        lamp_d  = lamp_q;
        if (ovr) begin
            phase_d = PH_VG;
            count_d = '0;
            lamp_d  = tl.blank ? L_OFF : !tl.test ? L_ALL : {1'b0, flash_d, 2'b00, flash_d, 1'b0};
        end else if (exit_ovr) begin
            phase_d = PH_VG;
            count_d = CNT_W'(T_VG);
            lamp_d  = L_VG;
        end else if (adv) begin
            phase_d = phase_e'(phase_q + 3'd1);
            count_d = CNT_W'(dur(phase_d, T_VG, T_HG, T_Y, T_YY));
            lamp_d  = lamps(phase_d);
        end else if (tick) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            phase_q <= PH_VG;
            count_q <= CNT_W'(T_VG);
            lamp_q  <= L_VG;
            flash_q <= 1'b1;
            fcnt_q  <= '0;
            fl_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            lamp_q  <= lamp_d;
            flash_q <= flash_d;
            fcnt_q  <= fcnt_d;
            fl_q    <= flk;
        end
    end

    assign tl.phase = phase_q;
    assign tl.count = count_q;
    assign {tl.hr, tl.hy, tl.hg, tl.vr, tl.vy, tl.vg} = lamp_q;
endmodule
